// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave to APB3 master bridge: one APB access per AHB beat, 2 (read) or 3 (write) wait states plus APB waits.
// Stalls the AHB data phase via hreadyout; misaligned/oversized/pslverr transfers get the two-cycle ERROR response.
module ahb_apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [1:0]        htrans,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t r_state;
  logic   w_accept;
  logic   w_illegal;

  assign w_accept  = hsel & hready & ((htrans == 2'b10) | (htrans == 2'b11));
  assign w_illegal = (hsize > 3'b010)
                   | ((hsize == 3'b001) & haddr[0])
                   | ((hsize == 3'b010) & (haddr[1:0] != 2'b00));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hrdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR2: begin
          if (w_accept) begin
            hreadyout <= 1'b0;
            if (w_illegal) begin
              r_state <= S_ERR1;
              hresp   <= 1'b1;
            end else begin
              // Address and direction are captured straight into the APB registers.
              paddr  <= haddr;
              pwrite <= hwrite;
              hresp  <= 1'b0;
              if (hwrite) begin
                r_state <= S_LATCH;
              end else begin
                r_state <= S_SETUP;
                psel    <= 1'b1;
              end
            end
          end else begin
            r_state   <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
        S_LATCH: begin
          pwdata  <= hwdata;
          psel    <= 1'b1;
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              r_state <= S_ERR1;
              hresp   <= 1'b1;
            end else begin
              if (!pwrite) hrdata <= prdata;
              r_state   <= S_DONE;
              hreadyout <= 1'b1;
            end
          end
        end
        S_ERR1: begin
          r_state   <= S_ERR2;
          hreadyout <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: a table of single transfers plus hand sequences
// for no-action inputs, back-to-back reads and reset in the middle of an APB access.
module tb_ahb_apb_bridge;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        hready_ovr;
  int          apb_wait;
  logic [31:0] apb_rdata;
  logic        apb_err;
  int          acc_cnt;

  int total;
  int bad;
  int cur_vec;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    logic        err;
    int          exp_waits;
    logic        exp_hresp;
    logic [31:0] exp_hrdata;
    int          exp_psel;
    int          exp_pen;
  } vec_t;

  vec_t vecs[10];

  ahb_apb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  assign hready = hreadyout & ~hready_ovr;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // APB slave: pready rises after apb_wait ACCESS cycles.
  always @(negedge hclk) begin
    if (psel && penable) begin
      pready  = (acc_cnt >= apb_wait);
      pslverr = pready && apb_err;
      prdata  = apb_rdata;
      acc_cnt = acc_cnt + 1;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h expected=%h", nm, cur_vec, act, exp);
    end
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic do_vec(input vec_t v);
    int   waits, psel_n, pen_n;
    logic done, got_setup, first_psel, last_hresp, comp_hresp, s_wr;
    logic [31:0] s_addr, s_wdata;
    waits = 0; psel_n = 0; pen_n = 0;
    done = 0; got_setup = 0; first_psel = 0; last_hresp = 0; comp_hresp = 0;
    s_wr = 0; s_addr = 0; s_wdata = 0;
    @(negedge hclk);
    apb_wait  = v.wait_n;
    apb_rdata = v.rdata;
    apb_err   = v.err;
    drive_addr(v.wr, v.size, v.addr);
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge hclk);
      if (k == 1) begin
        drive_idle();
        hwdata     = v.wdata;
        first_psel = psel;
      end
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (psel && !penable && !got_setup) begin
        got_setup = 1;
        s_addr    = paddr;
        s_wr      = pwrite;
        s_wdata   = pwdata;
      end
      if (hreadyout) begin
        done       = 1;
        comp_hresp = hresp;
      end else begin
        waits++;
        last_hresp = hresp;
      end
    end
    chk("completed", 32'(done), 32'd1);
    chk("wait_states", waits, v.exp_waits);
    chk("hresp_final", 32'(comp_hresp), 32'(v.exp_hresp));
    chk("hresp_last_wait", 32'(last_hresp), 32'(v.exp_hresp));
    chk("hrdata", hrdata, v.exp_hrdata);
    chk("psel_cycles", psel_n, v.exp_psel);
    chk("penable_cycles", pen_n, v.exp_pen);
    chk("psel_first_cycle", 32'(first_psel), 32'(!v.wr && v.exp_psel > 0));
    if (v.exp_psel > 0) begin
      chk("paddr_setup", s_addr, v.addr);
      chk("pwrite_setup", 32'(s_wr), 32'(v.wr));
      if (v.wr) chk("pwdata_setup", s_wdata, v.wdata);
    end
  endtask

  initial begin
    logic seen;
    total = 0; bad = 0; cur_vec = -1;
    hresetn = 1'b0; hready_ovr = 1'b0;
    hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 0; hwdata = 0;
    apb_wait = 0; apb_rdata = 0; apb_err = 0; acc_cnt = 0;
    pready = 0; pslverr = 0; prdata = 0;

    //            wr    size  addr          wdata         rdata         w  err  waits hresp hrdata        psel pen
    vecs[0] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 2, 1'b0, 32'hDEAD_BEEF, 2, 1};
    vecs[1] = '{1'b1, 3'd2, 32'h0000_0020, 32'h1234_5678, 32'h0,        2, 1'b0, 5, 1'b0, 32'hDEAD_BEEF, 4, 3};
    vecs[2] = '{1'b0, 3'd1, 32'h0000_0003, 32'h0,        32'h9999_9999, 0, 1'b0, 1, 1'b1, 32'hDEAD_BEEF, 0, 0};
    vecs[3] = '{1'b1, 3'd2, 32'h0000_0040, 32'hAAAA_5555, 32'h0,        0, 1'b1, 4, 1'b1, 32'hDEAD_BEEF, 2, 1};
    vecs[4] = '{1'b0, 3'd2, 32'h0000_0044, 32'h0,        32'h1111_1111, 1, 1'b1, 4, 1'b1, 32'hDEAD_BEEF, 3, 2};
    vecs[5] = '{1'b0, 3'd0, 32'h0000_0007, 32'h0,        32'h0000_00A5, 0, 1'b0, 2, 1'b0, 32'h0000_00A5, 2, 1};
    vecs[6] = '{1'b0, 3'd1, 32'h0000_0006, 32'h0,        32'h0000_BEEF, 1, 1'b0, 3, 1'b0, 32'h0000_BEEF, 3, 2};
    vecs[7] = '{1'b0, 3'd3, 32'h0000_0008, 32'h0,        32'h0,         0, 1'b0, 1, 1'b1, 32'h0000_BEEF, 0, 0};
    vecs[8] = '{1'b1, 3'd2, 32'h0000_0002, 32'h5555_5555, 32'h0,        0, 1'b0, 1, 1'b1, 32'h0000_BEEF, 0, 0};
    vecs[9] = '{1'b0, 3'd2, 32'h0000_001C, 32'h0,        32'hCAFE_F00D, 3, 1'b0, 5, 1'b0, 32'hCAFE_F00D, 5, 4};

    repeat (2) @(negedge hclk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    hresetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cur_vec = i;
      do_vec(vecs[i]);
    end

    // Inputs that must not start a transfer: BUSY, hsel low, hready low.
    cur_vec = 100;
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
    @(negedge hclk);
    chk("busy_psel", 32'(psel), 32'd0);
    chk("busy_hreadyout", 32'(hreadyout), 32'd1);
    hsel = 1'b0; htrans = 2'b10;
    @(negedge hclk);
    chk("nosel_psel", 32'(psel), 32'd0);
    chk("nosel_hreadyout", 32'(hreadyout), 32'd1);
    hsel = 1'b1; htrans = 2'b10; hready_ovr = 1'b1;
    @(negedge hclk);
    chk("nordy_psel", 32'(psel), 32'd0);
    chk("nordy_hreadyout", 32'(hreadyout), 32'd1);
    drive_idle(); hready_ovr = 1'b0;

    // Back-to-back reads, second address phase presented in DONE.
    cur_vec = 101;
    @(negedge hclk);
    apb_wait = 0; apb_err = 0; apb_rdata = 32'h0102_0304;
    drive_addr(1'b0, 3'd2, 32'h0000_0050);
    @(negedge hclk);
    drive_idle();
    chk("b2b_setup1_psel", 32'(psel), 32'd1);
    @(negedge hclk);
    chk("b2b_access1_penable", 32'(penable), 32'd1);
    @(negedge hclk);
    chk("b2b_done1_hreadyout", 32'(hreadyout), 32'd1);
    chk("b2b_done1_hrdata", hrdata, 32'h0102_0304);
    chk("b2b_done1_psel", 32'(psel), 32'd0);
    apb_rdata = 32'h0506_0708;
    drive_addr(1'b0, 3'd2, 32'h0000_0054);
    @(negedge hclk);
    drive_idle();
    chk("b2b_setup2_psel", 32'(psel), 32'd1);
    chk("b2b_setup2_penable", 32'(penable), 32'd0);
    chk("b2b_setup2_paddr", paddr, 32'h0000_0054);
    chk("b2b_setup2_hreadyout", 32'(hreadyout), 32'd0);
    @(negedge hclk);
    chk("b2b_access2_penable", 32'(penable), 32'd1);
    @(negedge hclk);
    chk("b2b_done2_hreadyout", 32'(hreadyout), 32'd1);
    chk("b2b_done2_hrdata", hrdata, 32'h0506_0708);

    // Asynchronous reset while the APB access is stalled.
    cur_vec = 102;
    @(negedge hclk);
    apb_wait = 10; apb_rdata = 32'h0000_0077;
    drive_addr(1'b0, 3'd2, 32'h0000_0060);
    @(negedge hclk);
    drive_idle();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge hclk);
      if (psel && penable) seen = 1'b1;
    end
    chk("rstmid_in_access", 32'(seen), 32'd1);
    #2 hresetn = 1'b0;
    #1;
    chk("rstmid_psel", 32'(psel), 32'd0);
    chk("rstmid_penable", 32'(penable), 32'd0);
    chk("rstmid_hresp", 32'(hresp), 32'd0);
    chk("rstmid_hreadyout", 32'(hreadyout), 32'd1);
    chk("rstmid_hrdata", hrdata, 32'd0);
    chk("rstmid_paddr", paddr, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    apb_wait = 0;

    cur_vec = 0;
    do_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
